// File: rtl/q88_mac_pe.sv
// Q8.8 signed multiply-accumulate PE: three register stages, one operation per clock.
// Define Q88_MAC_PE_SAT_EN for saturating product/accumulate; otherwise both wrap to 16 bits.
module q88_mac_pe #(
    parameter int FRAC_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] input_example_1_i,
    input  logic        input_example_2_i,
    output logic [15:0] output_example_o
);

    localparam int DATA_W = 16;
    localparam int MUL_W  = 2 * DATA_W;
    localparam int EXT_W  = MUL_W + 1;
    localparam logic signed [EXT_W-1:0] RND_BIAS = EXT_W'(1) <<< (FRAC_W - 1);

    // Round half up: add half an LSB of the result, then arithmetic shift.
    function automatic logic signed [EXT_W-1:0] round_q(input logic signed [MUL_W-1:0] p);
        logic signed [EXT_W-1:0] pe;
        pe = EXT_W'(p);
        return (pe + RND_BIAS) >>> FRAC_W;
    endfunction

`ifdef Q88_MAC_PE_SAT_EN
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [EXT_W-1:0] v);
        logic [EXT_W-DATA_W:0] hi;
        hi = v[EXT_W-1:DATA_W-1];
        if (hi == '0 || hi == '1)
            return v[DATA_W-1:0];
        else if (v[EXT_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction
`endif

    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [EXT_W-1:0] v);
`ifdef Q88_MAC_PE_SAT_EN
        return sat16(v);
`else
        return DATA_W'(v);
`endif
    endfunction

    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic                     mode_p0;
    logic signed [DATA_W-1:0] prod_p1;
    logic                     mode_p1;
    logic signed [DATA_W-1:0] acc_p2;

    logic signed [MUL_W-1:0]  mul_full;
    logic signed [DATA_W-1:0] prod_nxt;
    logic signed [DATA_W:0]   sum_17;
    logic signed [DATA_W-1:0] acc_nxt;

    // S1: capture operands and mode; mode resets to accumulate so flushed zeros hold acc at 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_p0    <= '0;
            b_p0    <= '0;
            mode_p0 <= 1'b1;
        end else begin
            a_p0    <= input_example_1_i[31:16];
            b_p0    <= input_example_1_i[15:0];
            mode_p0 <= input_example_2_i;
        end
    end

    always_comb begin
        mul_full = MUL_W'(a_p0) * MUL_W'(b_p0);
        prod_nxt = narrow(round_q(mul_full));
    end

    // S2: rounded, narrowed product.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_p1 <= '0;
            mode_p1 <= 1'b1;
        end else begin
            prod_p1 <= prod_nxt;
            mode_p1 <= mode_p0;
        end
    end

    always_comb begin
        sum_17  = (DATA_W+1)'(acc_p2) + (DATA_W+1)'(prod_p1);
        acc_nxt = mode_p1 ? narrow(EXT_W'(sum_17)) : prod_p1;
    end

    // S3: accumulator; the adder reads the value written on the previous edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            acc_p2 <= '0;
        else
            acc_p2 <= acc_nxt;
    end

    assign output_example_o = acc_p2;

endmodule

// File: tb/tb_q88_mac_pe.sv
// Bench for q88_mac_pe: vector table, reset sequences and randomized run against a Q8.8 model.
module tb_q88_mac_pe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in1;
    logic        in2;
    logic [15:0] dout;

    int total = 0;
    int bad   = 0;

    q88_mac_pe #(.FRAC_W(8)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .input_example_1_i (in1),
        .input_example_2_i (in2),
        .output_example_o  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] e_sat;
        logic [15:0] e_wrap;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic longint to_q16(input longint v);
        logic signed [15:0] t;
`ifdef Q88_MAC_PE_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        t = v[15:0];
        return longint'(t);
`endif
    endfunction

    // Real-valued product rounded half up: floor((a*b + 128) / 256).
    function automatic longint q_prod(input logic [15:0] a, input logic [15:0] b);
        longint p, q;
        p = longint'($signed(a)) * longint'($signed(b)) + 128;
        q = p / 256;
        if ((p % 256 != 0) && (p < 0)) q = q - 1;
        return to_q16(q);
    endfunction

    function automatic logic [15:0] pick(input vec_t v);
`ifdef Q88_MAC_PE_SAT_EN
        return v.e_sat;
`else
        return v.e_wrap;
`endif
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic m);
        in1 = {a, b};
        in2 = m;
    endtask

    longint      acc_m;
    logic [15:0] exp_q[1000];
    logic [15:0] ra, rb;
    logic        rm;

    initial begin
        tbl[0]  = '{16'h0100, 16'h0200, 1'b0, 16'h0200, 16'h0200};
        tbl[1]  = '{16'h0100, 16'h0200, 1'b1, 16'h0400, 16'h0400};
        tbl[2]  = '{16'hFF00, 16'h0300, 1'b0, 16'hFD00, 16'hFD00};
        tbl[3]  = '{16'h0100, 16'h0300, 1'b1, 16'h0000, 16'h0000};
        tbl[4]  = '{16'h0001, 16'h0080, 1'b0, 16'h0001, 16'h0001};
        tbl[5]  = '{16'h0001, 16'h007F, 1'b0, 16'h0000, 16'h0000};
        tbl[6]  = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 16'hFF00};
        tbl[7]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h8000, 16'h0080};
        tbl[8]  = '{16'h8000, 16'h8000, 1'b0, 16'h7FFF, 16'h0000};
        tbl[9]  = '{16'h7F00, 16'h0100, 1'b0, 16'h7F00, 16'h7F00};
        tbl[10] = '{16'h0200, 16'h0100, 1'b1, 16'h7FFF, 16'h8100};
        tbl[11] = '{16'h0100, 16'h0100, 1'b0, 16'h0100, 16'h0100};
        tbl[12] = '{16'h7FFF, 16'h0100, 1'b0, 16'h7FFF, 16'h7FFF};
        tbl[13] = '{16'h0100, 16'h0100, 1'b1, 16'h7FFF, 16'h80FF};
        tbl[14] = '{16'h8000, 16'h0100, 1'b0, 16'h8000, 16'h8000};
        tbl[15] = '{16'hFF00, 16'h0100, 1'b1, 16'h8000, 16'h7F00};

        // Power-on reset
        rst_n = 1'b0;
        drive(16'h0, 16'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("por_hold", dout, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("por_release", dout, 16'h0000);
        end

        // Vector table, back to back, result for op c visible after edge c+2
        for (int c = 0; c < 18; c++) begin
            if (c < 16) drive(tbl[c].a, tbl[c].b, tbl[c].m);
            else        drive(16'h0, 16'h0, 1'b1);
            @(negedge clk);
            if (c >= 2) chk($sformatf("vec%0d", c - 2), dout, pick(tbl[c-2]));
        end

        // Reset mid-stream with loads in flight
        for (int c = 0; c < 4; c++) begin
            drive(16'h0100, 16'h0300, 1'b0);
            @(negedge clk);
        end
        chk("pre_reset", dout, 16'h0300);
        drive(16'h0200, 16'h0200, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_immediate", dout, 16'h0000);
        @(negedge clk);
        chk("reset_held", dout, 16'h0000);
        drive(16'h0, 16'h0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_flush", dout, 16'h0000);
        end

        // Randomized run against the model
        acc_m = 0;
        for (int c = 0; c < 1002; c++) begin
            if (c < 1000) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rm = 1'($urandom_range(0, 3) != 0);
                if (c % 97 == 0) ra = 16'h8000;
                drive(ra, rb, rm);
                if (rm) acc_m = to_q16(acc_m + q_prod(ra, rb));
                else    acc_m = q_prod(ra, rb);
                exp_q[c] = 16'(acc_m);
            end else begin
                drive(16'h0, 16'h0, 1'b1);
            end
            @(negedge clk);
            if (c >= 2) chk($sformatf("rand%0d", c - 2), dout, exp_q[c-2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
